demultiplexeur_tdm_1bitx4: RTL and testbench

- Receive-side counterpart of the 4:1 one-bit multiplexer.
- Takes the 1-bit time-division stream produced by a mux whose select rotates 0,1,2,3 and rebuilds the parallel channels a,b,c,d.
- Aligns to a frame-start marker and tracks the slot with an internal counter.
- Captures the slots into shadow registers and presents a complete frame with a one-cycle valid pulse.
- Sits at the far end of a serial link, between the line and the parallel consumer logic.

---
 rtl/demultiplexeur_tdm_1bitx4_pkg.sv | 16 +
 rtl/demultiplexeur_tdm_1bitx4_compteur_slot.sv | 54 +++++
 rtl/demultiplexeur_tdm_1bitx4.sv | 131 +++++++++++++
 tb/tb_demultiplexeur_tdm_1bitx4.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/demultiplexeur_tdm_1bitx4_pkg.sv
// Shared definitions for the 1-bit x4 TDM link (mux and demux ends).
// Holds the default frame geometry, so both ends agree on the frame
// size, and the alignment state encoding of the receive side.
package demultiplexeur_tdm_1bitx4_pkg;

  // Default number of time slots per frame and matching slot-index width.
  localparam int NB_CH_DEF = 4;
  localparam int SEL_W_DEF = 2;

  // Receive-side alignment state: hunting for a marker, or aligned.
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } align_state_e;

endpackage

// File: rtl/demultiplexeur_tdm_1bitx4_compteur_slot.sv
// Slot counter shared by both ends of the TDM link.
// A SEL_W-bit counter that wraps modulo NB_CH, with an increment enable
// and a synchronous load-to-1. The load-to-1 is used when a frame marker
// has just been consumed as slot 0.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset (count returns to 0)
//   inc      : advance the count by one, wrapping at NB_CH
//   load_one : force the count to 1 (has priority over inc)
//   count    : current slot index
//   terminal : high when count == NB_CH-1
module demultiplexeur_tdm_1bitx4_compteur_slot
  import demultiplexeur_tdm_1bitx4_pkg::*;
#(
  parameter int NB_CH = NB_CH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load_one,
  output logic [SEL_W-1:0] count,
  output logic             terminal
);

  logic [SEL_W-1:0] count_q;
  logic [SEL_W-1:0] count_d;

  // Next count: load-to-1 wins over increment; otherwise hold.
  always_comb begin
    count_d = count_q;
    if (load_one) begin
      count_d = SEL_W'(1);
    end else if (inc) begin
      // NB_CH is a power of two, so natural overflow gives the wrap.
      count_d = count_q + SEL_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= {SEL_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == SEL_W'(NB_CH - 1));

endmodule

// File: rtl/demultiplexeur_tdm_1bitx4.sv
// Receive side of a 4:1 one-bit TDM link.
// Rebuilds the parallel channels from the serial stream of a mux whose
// select rotates 0..NB_CH-1. Aligns on a frame-start marker, captures
// each slot into a shadow register and publishes a complete frame on
// dout together with a one-cycle frame_valid pulse.
// Ports:
//   clk         : rising-edge clock
//   rst_n       : synchronous active-low reset
//   en          : sample strobe, one slot consumed per en=1 cycle
//   sync        : frame-start marker, qualified by en (din is slot 0)
//   din         : serial data
//   slot        : slot the next qualified sample will be written to
//   locked      : frame alignment held
//   dout        : last complete frame, bit k = slot k
//   frame_valid : one-cycle pulse when dout is updated
//   sync_err    : one-cycle pulse when a marker arrives mid-frame
module demultiplexeur_tdm_1bitx4
  import demultiplexeur_tdm_1bitx4_pkg::*;
#(
  parameter int NB_CH = NB_CH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             din,
  output logic [SEL_W-1:0] slot,
  output logic             locked,
  output logic [NB_CH-1:0] dout,
  output logic             frame_valid,
  output logic             sync_err
);

  align_state_e     state_q, state_d;
  logic [NB_CH-1:0] shadow_q, shadow_d;
  logic [NB_CH-1:0] dout_q, dout_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;

  logic             cnt_inc_s;
  logic             cnt_load_s;
  logic [SEL_W-1:0] slot_s;
  logic             terminal_s;

  demultiplexeur_tdm_1bitx4_compteur_slot #(
    .NB_CH (NB_CH),
    .SEL_W (SEL_W)
  ) u_compteur_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (cnt_inc_s),
    .load_one (cnt_load_s),
    .count    (slot_s),
    .terminal (terminal_s)
  );

  // Alignment FSM next-state, slot capture and frame publication.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    dout_d        = dout_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    cnt_inc_s     = 1'b0;
    cnt_load_s    = 1'b0;
    if (en) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d[0] = din;
            cnt_load_s  = 1'b1;
            state_d     = LOCKED;
          end else begin
            // Unaligned samples are dropped.
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (sync && (slot_s != {SEL_W{1'b0}})) begin
            // Marker mid-frame: drop the partial frame and re-align on
            // this sample as slot 0 without going back to hunting.
            sync_err_d  = 1'b1;
            shadow_d[0] = din;
            cnt_load_s  = 1'b1;
          end else begin
            shadow_d[slot_s] = din;
            cnt_inc_s        = 1'b1;
            if (terminal_s) begin
              // Last slot goes straight to dout on the same edge.
              dout_d        = {din, shadow_q[NB_CH-2:0]};
              frame_valid_d = 1'b1;
            end else begin
              dout_d = dout_q;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end else begin
      // No strobe: everything holds, pulses drop.
      state_d = state_q;
    end
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      shadow_q      <= {NB_CH{1'b0}};
      dout_q        <= {NB_CH{1'b0}};
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign slot        = slot_s;
  assign locked      = (state_q == LOCKED);
  assign dout        = dout_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_demultiplexeur_tdm_1bitx4.sv
// Self-checking bench for demultiplexeur_tdm_1bitx4: a hand-written
// vector table for the directed scenarios, then randomized traffic
// checked against a frame-level reference model.
module tb_demultiplexeur_tdm_1bitx4;

  localparam int NB = 4;
  localparam int SW = 2;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          sync;
  logic          din;
  logic [SW-1:0] slot;
  logic          locked;
  logic [NB-1:0] dout;
  logic          frame_valid;
  logic          sync_err;

  int n_vec;
  int n_err;

  typedef struct {
    logic          rst_n;
    logic          en;
    logic          sync;
    logic          din;
    logic [SW-1:0] slot;
    logic          locked;
    logic [NB-1:0] dout;
    logic          fv;
    logic          err;
  } vec_t;

  vec_t tbl[$];

  // Reference model state (frame-level view).
  bit m_locked;
  int m_pos;
  int m_bits[NB];
  int m_dout;
  bit m_fv;
  bit m_err;

  demultiplexeur_tdm_1bitx4 #(.NB_CH(NB), .SEL_W(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sync        (sync),
    .din         (din),
    .slot        (slot),
    .locked      (locked),
    .dout        (dout),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic s, input logic d,
                     input int sl, input logic lk, input logic [NB-1:0] dv,
                     input logic fv, input logic er);
    vec_t v;
    v.rst_n = r; v.en = e; v.sync = s; v.din = d;
    v.slot = SW'(sl); v.locked = lk; v.dout = dv; v.fv = fv; v.err = er;
    tbl.push_back(v);
  endtask

  task automatic compare(input string name, input int idx,
                         input logic [SW-1:0] e_slot, input logic e_lk,
                         input logic [NB-1:0] e_dout, input logic e_fv,
                         input logic e_err);
    logic [8:0] got;
    logic [8:0] exp;
    got = {slot, locked, dout, frame_valid, sync_err};
    exp = {e_slot, e_lk, e_dout, e_fv, e_err};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got slot=%0d locked=%b dout=%b fv=%b err=%b, expected slot=%0d locked=%b dout=%b fv=%b err=%b",
               name, idx, slot, locked, dout, frame_valid, sync_err,
               e_slot, e_lk, e_dout, e_fv, e_err);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit s, input bit d);
    if (!r) begin
      m_locked = 1'b0; m_pos = 0; m_dout = 0; m_fv = 1'b0; m_err = 1'b0;
      for (int k = 0; k < NB; k++) m_bits[k] = 0;
    end else begin
      m_fv = 1'b0;
      m_err = 1'b0;
      if (e) begin
        if (!m_locked) begin
          if (s) begin
            m_locked = 1'b1; m_bits[0] = int'(d); m_pos = 1;
          end
        end else if (s && m_pos != 0) begin
          m_err = 1'b1; m_bits[0] = int'(d); m_pos = 1;
        end else begin
          m_bits[m_pos] = int'(d);
          m_pos++;
          if (m_pos == NB) begin
            m_dout = 0;
            for (int k = 0; k < NB; k++) m_dout += m_bits[k] * (1 << k);
            m_fv = 1'b1;
            m_pos = 0;
          end
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; din = 1'b0;

    //    rst en sy din slot lk dout     fv er
    add(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);   // reset
    add(0, 1, 1, 1, 0, 0, 4'b0000, 0, 0);   // reset beats sync
    add(1, 1, 0, 1, 0, 0, 4'b0000, 0, 0);   // hunt discard x3
    add(1, 1, 0, 1, 0, 0, 4'b0000, 0, 0);
    add(1, 1, 0, 1, 0, 0, 4'b0000, 0, 0);
    add(1, 1, 1, 1, 1, 1, 4'b0000, 0, 0);   // align, frame 1,0,1,1
    add(1, 1, 0, 0, 2, 1, 4'b0000, 0, 0);
    add(1, 1, 0, 1, 3, 1, 4'b0000, 0, 0);
    add(1, 1, 0, 1, 0, 1, 4'b1101, 1, 0);
    add(1, 1, 0, 0, 1, 1, 4'b1101, 0, 0);   // frame 0,1,0,1
    add(1, 1, 0, 1, 2, 1, 4'b1101, 0, 0);
    add(1, 1, 0, 0, 3, 1, 4'b1101, 0, 0);
    add(1, 1, 0, 1, 0, 1, 4'b1010, 1, 0);
    add(1, 1, 0, 1, 1, 1, 4'b1010, 0, 0);   // frame 1,1,1,1
    add(1, 1, 0, 1, 2, 1, 4'b1010, 0, 0);
    add(1, 1, 0, 1, 3, 1, 4'b1010, 0, 0);
    add(1, 1, 0, 1, 0, 1, 4'b1111, 1, 0);
    add(1, 1, 0, 1, 1, 1, 4'b1111, 0, 0);   // frame 1,0,0,1 with en gaps
    add(1, 0, 0, 0, 1, 1, 4'b1111, 0, 0);
    add(1, 1, 0, 0, 2, 1, 4'b1111, 0, 0);
    add(1, 0, 0, 1, 2, 1, 4'b1111, 0, 0);
    add(1, 1, 0, 0, 3, 1, 4'b1111, 0, 0);
    add(1, 0, 1, 1, 3, 1, 4'b1111, 0, 0);   // sync ignored without en
    add(1, 1, 0, 1, 0, 1, 4'b1001, 1, 0);
    add(1, 0, 0, 0, 0, 1, 4'b1001, 0, 0);   // pulse drops on en=0
    add(1, 1, 1, 1, 1, 1, 4'b1001, 0, 0);   // sync at slot 0: no error
    add(1, 1, 0, 1, 2, 1, 4'b1001, 0, 0);
    add(1, 1, 1, 0, 1, 1, 4'b1001, 0, 1);   // sync at slot 2: error
    add(1, 1, 0, 1, 2, 1, 4'b1001, 0, 0);
    add(1, 1, 0, 0, 3, 1, 4'b1001, 0, 0);
    add(1, 1, 0, 1, 0, 1, 4'b1010, 1, 0);   // new frame 0,1,0,1
    add(1, 1, 0, 1, 1, 1, 4'b1010, 0, 0);
    add(1, 1, 0, 1, 2, 1, 4'b1010, 0, 0);
    add(1, 1, 0, 1, 3, 1, 4'b1010, 0, 0);
    add(1, 1, 1, 1, 1, 1, 4'b1010, 0, 1);   // sync at last slot: error
    add(1, 1, 0, 1, 2, 1, 4'b1010, 0, 0);
    add(0, 1, 0, 1, 0, 0, 4'b0000, 0, 0);   // reset mid-frame
    add(1, 1, 0, 1, 0, 0, 4'b0000, 0, 0);   // no sync: ignored
    add(1, 1, 0, 0, 0, 0, 4'b0000, 0, 0);
    add(1, 1, 0, 1, 0, 0, 4'b0000, 0, 0);
    add(1, 1, 0, 1, 0, 0, 4'b0000, 0, 0);
    add(1, 0, 1, 1, 0, 0, 4'b0000, 0, 0);   // sync without en in hunt

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; en = tbl[i].en; sync = tbl[i].sync; din = tbl[i].din;
      @(posedge clk);
      #1;
      compare("table", i, tbl[i].slot, tbl[i].locked, tbl[i].dout,
              tbl[i].fv, tbl[i].err);
    end

    // Randomized traffic, starting from a reset shared by model and DUT.
    for (int i = 0; i < 3000; i++) begin
      bit r, e, s, d;
      r = (i == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) == 0);
      d = 1'($urandom_range(0, 1));
      @(negedge clk);
      rst_n = r; en = e; sync = s; din = d;
      @(posedge clk);
      model_step(r, e, s, d);
      #1;
      compare("random", i, SW'(m_pos), m_locked, NB'(m_dout), m_fv, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
